// File: rtl/video_timing_pkg.sv
// 640x480@60 region lengths and helpers shared by the video path.
package video_timing_pkg;

  localparam int vga_h_active = 640;
  localparam int vga_h_front  = 16;
  localparam int vga_h_sync   = 96;
  localparam int vga_h_back   = 48;
  localparam int vga_v_active = 480;
  localparam int vga_v_front  = 10;
  localparam int vga_v_sync   = 2;
  localparam int vga_v_back   = 33;

  typedef enum logic [1:0] {
    reg_active,
    reg_front,
    reg_sync,
    reg_back
  } region_e;

  function automatic int h_total_of(
    input int act, input int fp, input int sy, input int bp
  );
    return act + fp + sy + bp;
  endfunction

  function automatic int v_total_of(
    input int act, input int fp, input int sy, input int bp
  );
    return act + fp + sy + bp;
  endfunction

  function automatic region_e region_of(
    input int pos, input int act, input int fp, input int sy
  );
    if (pos < act) return reg_active;
    if (pos < act + fp) return reg_front;
    if (pos < act + fp + sy) return reg_sync;
    return reg_back;
  endfunction

endpackage

// File: rtl/video_timing_gen_strobe_gen.sv
// Pixel-rate divider: registered strobe, one clk wide,
// high while the divide counter sits at ratio-1.
module strobe_gen #(
  parameter int ratio = 2
) (
  input  logic clk,
  input  logic rst,
  output logic strobe
);

  localparam int w = (ratio > 1) ? $clog2(ratio) : 1;
  localparam logic [w-1:0] last = w'(ratio - 1);

  logic [w-1:0] div_cnt_q, div_cnt_d;
  logic         strobe_q, strobe_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == last) ? '0 : div_cnt_q + w'(1);
    strobe_d  = (div_cnt_d == last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      strobe_q  <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster counters and registered sync/blank decode for a
// progressive video mode, advanced by a divided pixel strobe.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int clk_mhz   = 50,
  parameter int pixel_mhz = 25,
  parameter int h_active  = vga_h_active,
  parameter int h_front   = vga_h_front,
  parameter int h_sync    = vga_h_sync,
  parameter int h_back    = vga_h_back,
  parameter int v_active  = vga_v_active,
  parameter int v_front   = vga_v_front,
  parameter int v_sync    = vga_v_sync,
  parameter int v_back    = vga_v_back,
  parameter int w_x =
    $clog2(h_total_of(h_active, h_front, h_sync, h_back)),
  parameter int w_y =
    $clog2(v_total_of(v_active, v_front, v_sync, v_back))
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pixel_en,
  output logic [w_x-1:0] x,
  output logic [w_y-1:0] y,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic           line_start,
  output logic           frame_start
);

  localparam int h_total =
    h_total_of(h_active, h_front, h_sync, h_back);
  localparam int v_total =
    v_total_of(v_active, v_front, v_sync, v_back);
  localparam bit ratio_ok = (pixel_mhz > 0) ?
    (clk_mhz >= pixel_mhz && clk_mhz % pixel_mhz == 0) : 1'b0;
  localparam int ratio = ratio_ok ? clk_mhz / pixel_mhz : 1;

  localparam logic [w_x-1:0] x_last = w_x'(h_total - 1);
  localparam logic [w_y-1:0] y_last = w_y'(v_total - 1);

  generate
    if (!ratio_ok) begin : g_bad_ratio
      $error("clk_mhz must be an integer multiple of pixel_mhz");
    end
  endgenerate

  logic           strobe;
  logic [w_x-1:0] x_q, x_d;
  logic [w_y-1:0] y_q, y_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           display_on_q, display_on_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;

  strobe_gen #(
    .ratio (ratio)
  ) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .strobe (strobe)
  );

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (strobe) begin
      if (x_q == x_last) begin
        x_d = '0;
        y_d = (y_q == y_last) ? '0 : y_q + w_y'(1);
      end else begin
        x_d = x_q + w_x'(1);
      end
    end
    // Decode from next values so flags line up with x/y.
    line_start_d  = strobe && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
    hsync_d = region_of(int'(x_d), h_active, h_front, h_sync)
              == reg_sync;
    vsync_d = region_of(int'(y_d), v_active, v_front, v_sync)
              == reg_sync;
    display_on_d = (int'(x_d) < h_active) &&
                   (int'(y_d) < v_active);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q           <= x_last;
      y_q           <= y_last;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_en    = strobe;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
